// File: rtl/fir_filter_param.sv
// Parametrised direct-form FIR filter: valid-qualified sample stream, run-time writable
// coefficients, rounding right shift and saturating output with a clip flag.
module fir_filter_param #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        xn,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic                     clear,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         yn,
    output logic                     sat
);

    localparam int AW    = $clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + AW;
    // One guard bit so the rounding constant can never overflow the accumulator.
    localparam int RW    = ACC_W + 1;
    localparam int CW    = ((RW > OUT_W) ? RW : OUT_W) + 1;

    localparam logic signed [CW-1:0] MAX_V = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CW-1:0] MIN_V = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [DATA_W-1:0] x_q    [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [DATA_W-1:0] tap    [TAPS];
    logic signed [PW-1:0]     prod   [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic signed [RW-1:0]     acc_ext;
    logic signed [RW-1:0]     r;
    logic signed [CW-1:0]     r_ext;
    logic [OUT_W-1:0]         y_d;
    logic                     sat_d;
    logic                     out_valid_q;
    logic [OUT_W-1:0]         yn_q;
    logic                     sat_q;

    // The incoming sample is part of this cycle's sum, so tap 0 is xn, not x_q[0].
    always_comb begin
        tap[0] = $signed(xn);
        for (int k = 1; k < TAPS; k++) begin
            tap[k] = x_q[k-1];
        end
    end

    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            prod[k] = PW'(tap[k]) * PW'(coef_q[k]);
            acc     = acc + ACC_W'(prod[k]);
        end
    end

    assign acc_ext = RW'(acc);

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
            assign r = (acc_ext + HALF) >>> SHIFT;
        end else begin : g_no_round
            assign r = acc_ext;
        end
    endgenerate

    assign r_ext = CW'(r);

    always_comb begin
        sat_d = 1'b0;
        y_d   = r_ext[OUT_W-1:0];
        if (r_ext > MAX_V) begin
            sat_d = 1'b1;
            y_d   = MAX_V[OUT_W-1:0];
        end else if (r_ext < MIN_V) begin
            sat_d = 1'b1;
            y_d   = MIN_V[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                if (k == 0) coef_q[k] <= COEF_W'(1);
                else        coef_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            yn_q        <= '0;
            sat_q       <= 1'b0;
        end else begin
            if (clear) begin
                for (int k = 0; k < TAPS; k++) begin
                    x_q[k] <= '0;
                end
                out_valid_q <= 1'b0;
            end else if (in_valid) begin
                x_q[0] <= $signed(xn);
                for (int k = 1; k < TAPS; k++) begin
                    x_q[k] <= x_q[k-1];
                end
                out_valid_q <= 1'b1;
                yn_q        <= y_d;
                sat_q       <= sat_d;
            end else begin
                out_valid_q <= 1'b0;
            end
            // Addresses at or beyond TAPS match no tap and are silently dropped.
            for (int k = 0; k < TAPS; k++) begin
                if (coef_we && (coef_addr == AW'(k))) begin
                    coef_q[k] <= $signed(coef_data);
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign yn        = yn_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench: four filter configurations share one stimulus stream and are
// compared against a plain-arithmetic reference model, plus directed tables and sequences.
module tb_fir_filter_param;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [15:0]       xn;
    logic              coef_we;
    logic [2:0]        coef_addr;
    logic [15:0]       coef_data;
    logic              clear;

    logic              ov_a, ov_b, ov_c, ov_d;
    logic signed [31:0] yn_a, yn_c, yn_d;
    logic signed [15:0] yn_b;
    logic              sat_a, sat_b, sat_c, sat_d;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fir_filter_param u_a (.clk(clk), .reset(reset), .in_valid(in_valid), .xn(xn), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .clear(clear), .out_valid(ov_a), .yn(yn_a), .sat(sat_a));
    fir_filter_param #(.OUT_W(16)) u_b (.clk(clk), .reset(reset), .in_valid(in_valid), .xn(xn), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .clear(clear), .out_valid(ov_b), .yn(yn_b), .sat(sat_b));
    fir_filter_param #(.SHIFT(2)) u_c (.clk(clk), .reset(reset), .in_valid(in_valid), .xn(xn), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .clear(clear), .out_valid(ov_c), .yn(yn_c), .sat(sat_c));
    fir_filter_param #(.TAPS(5)) u_d (.clk(clk), .reset(reset), .in_valid(in_valid), .xn(xn), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .clear(clear), .out_valid(ov_d), .yn(yn_d), .sat(sat_d));

    // Per-instance configuration seen by the reference model.
    int CT [4] = '{8, 8, 8, 5};
    int CO [4] = '{32, 16, 32, 32};
    int CS [4] = '{0, 0, 2, 0};

    longint mcoef [4][8];
    longint mhist [8];
    longint last_y [4];
    bit     last_s [4];

    typedef struct {
        bit     v;
        int     x;
        bit     we;
        int     addr;
        int     data;
        bit     clr;
        bit     expv;
        longint expy;
    } vec_t;
    vec_t tbl [14];

    function automatic void check(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic longint get_y(input int i);
        case (i)
            0:       return longint'(yn_a);
            1:       return longint'(yn_b);
            2:       return longint'(yn_c);
            default: return longint'(yn_d);
        endcase
    endfunction

    function automatic bit get_v(input int i);
        case (i)
            0:       return ov_a;
            1:       return ov_b;
            2:       return ov_c;
            default: return ov_d;
        endcase
    endfunction

    function automatic bit get_s(input int i);
        case (i)
            0:       return sat_a;
            1:       return sat_b;
            2:       return sat_c;
            default: return sat_d;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8; k++) mcoef[i][k] = (k == 0) ? 1 : 0;
            last_y[i] = 0;
            last_s[i] = 1'b0;
        end
        for (int k = 0; k < 8; k++) mhist[k] = 0;
    endfunction

    // Sum of products over the newest sample and stored history, then round and clip.
    function automatic void model_eval(input int i, input longint x, output longint y, output bit s);
        longint acc, r, hi, lo;
        acc = mcoef[i][0] * x;
        for (int k = 1; k < CT[i]; k++) acc += mcoef[i][k] * mhist[k-1];
        if (CS[i] > 0) r = (acc + (longint'(1) <<< (CS[i] - 1))) >>> CS[i];
        else           r = acc;
        hi = (longint'(1) <<< (CO[i] - 1)) - 1;
        lo = -(longint'(1) <<< (CO[i] - 1));
        s = 1'b0;
        y = r;
        if (r > hi) begin y = hi; s = 1'b1; end
        else if (r < lo) begin y = lo; s = 1'b1; end
    endfunction

    task automatic step(input bit v, input longint x, input bit we, input int addr, input longint data, input bit clr);
        bit ev;
        @(negedge clk);
        in_valid  = v;
        xn        = 16'(x);
        coef_we   = we;
        coef_addr = 3'(addr);
        coef_data = 16'(data);
        clear     = clr;
        ev = v && !clr;
        if (ev) begin
            for (int i = 0; i < 4; i++) model_eval(i, x, last_y[i], last_s[i]);
        end
        if (clr) begin
            for (int k = 0; k < 8; k++) mhist[k] = 0;
        end else if (v) begin
            for (int k = 7; k > 0; k--) mhist[k] = mhist[k-1];
            mhist[0] = x;
        end
        if (we) begin
            for (int i = 0; i < 4; i++) if (addr < CT[i]) mcoef[i][addr] = data;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("model_out_valid[%0d]", i), longint'(get_v(i)), longint'(ev));
            check($sformatf("model_yn[%0d]", i), get_y(i), last_y[i]);
            if (ev) check($sformatf("model_sat[%0d]", i), longint'(get_s(i)), longint'(last_s[i]));
        end
        in_valid = 1'b0;
        coef_we  = 1'b0;
        clear    = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1, 100, 0, 0, 0, 0, 1, 100};
        tbl[1]  = '{1, 200, 0, 0, 0, 0, 1, 200};
        tbl[2]  = '{1, 300, 0, 0, 0, 0, 1, 300};
        tbl[3]  = '{1, 400, 0, 0, 0, 0, 1, 400};
        tbl[4]  = '{0, 0,   1, 1, 1, 0, 0, 400};
        tbl[5]  = '{0, 0,   1, 2, 1, 0, 0, 400};
        tbl[6]  = '{0, 0,   1, 3, 1, 0, 0, 400};
        tbl[7]  = '{0, 0,   0, 0, 0, 1, 0, 400};
        tbl[8]  = '{1, 100, 0, 0, 0, 0, 1, 100};
        tbl[9]  = '{1, 200, 0, 0, 0, 0, 1, 300};
        tbl[10] = '{1, 300, 0, 0, 0, 0, 1, 600};
        tbl[11] = '{1, 400, 0, 0, 0, 0, 1, 1000};
        tbl[12] = '{1, 0,   0, 0, 0, 0, 1, 900};
        tbl[13] = '{1, 0,   0, 0, 0, 0, 1, 700};

        reset = 1'b0; in_valid = 1'b0; xn = '0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_out_valid[%0d]", i), longint'(get_v(i)), 0);
            check($sformatf("reset_yn[%0d]", i), get_y(i), 0);
            check($sformatf("reset_sat[%0d]", i), longint'(get_s(i)), 0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Pass-through then four-tap moving sum.
        for (int n = 0; n < 14; n++) begin
            step(tbl[n].v, tbl[n].x, tbl[n].we, tbl[n].addr, tbl[n].data, tbl[n].clr);
            check($sformatf("tbl_out_valid[%0d]", n), longint'(ov_a), longint'(tbl[n].expv));
            check($sformatf("tbl_yn[%0d]", n), longint'(yn_a), tbl[n].expy);
            if (tbl[n].expv) check($sformatf("tbl_sat[%0d]", n), longint'(sat_a), 0);
        end

        // Impulse response with coef[k]=k+1; the 5-tap instance ignores addresses 5..7.
        for (int k = 0; k < 8; k++) step(0, 0, 1, k, k + 1, 0);
        step(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 10; n++) begin
            step(1, (n == 0) ? 1 : 0, 0, 0, 0, 0);
            check($sformatf("impulse_yn[%0d]", n), longint'(yn_a), (n < 8) ? n + 1 : 0);
            if (n == 4) check("impulse_taps5_last", longint'(yn_d), 5);
            if (n == 5) check("impulse_taps5_beyond", longint'(yn_d), 0);
        end

        // Saturation on the 16-bit output instance.
        step(0, 0, 1, 0, 2, 0);
        for (int k = 1; k < 8; k++) step(0, 0, 1, k, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, 30000, 0, 0, 0, 0);
        check("sat_pos_yn", longint'(yn_b), 32767);
        check("sat_pos_flag", longint'(sat_b), 1);
        check("nosat_wide_yn", longint'(yn_a), 60000);
        check("nosat_wide_flag", longint'(sat_a), 0);
        step(1, -30000, 0, 0, 0, 0);
        check("sat_neg_yn", longint'(yn_b), -32768);
        check("sat_neg_flag", longint'(sat_b), 1);

        // Rounding shift by 2 with a gap in the sample stream.
        step(0, 0, 1, 0, 1, 0);
        step(1, 6, 0, 0, 0, 0);
        check("round_pos6", longint'(yn_c), 2);
        step(1, -6, 0, 0, 0, 0);
        check("round_neg6", longint'(yn_c), -1);
        step(0, 0, 0, 0, 0, 0);
        check("gap_out_valid", longint'(ov_c), 0);
        check("gap_yn_hold", longint'(yn_c), -1);
        step(1, 2, 0, 0, 0, 0);
        check("round_half_up", longint'(yn_c), 1);
        step(1, -2, 0, 0, 0, 0);
        check("round_neg_half", longint'(yn_c), 0);

        // Coefficient write alongside a sample uses the old coefficient.
        step(1, 10, 1, 0, 3, 0);
        check("we_old_coef", longint'(yn_a), 10);
        step(1, 10, 0, 0, 0, 0);
        check("we_new_coef", longint'(yn_a), 30);
        step(0, 0, 1, 1, 1, 0);
        // Clear beats in_valid; the coefficient write in that cycle still lands.
        step(1, 50, 1, 2, 5, 1);
        check("clear_drops_sample", longint'(ov_a), 0);
        step(1, 7, 0, 0, 0, 0);
        check("clear_zeroes_history", longint'(yn_a), 21);
        step(1, 0, 0, 0, 0, 0);
        check("clear_hist_tap1", longint'(yn_a), 7);
        step(1, 0, 0, 0, 0, 0);
        check("clear_coef_write", longint'(yn_a), 35);

        // Asynchronous reset mid-stream.
        step(1, 77, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out_valid", longint'(ov_a), 0);
        check("async_rst_yn", longint'(yn_a), 0);
        check("async_rst_sat", longint'(sat_b), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1, 123, 0, 0, 0, 0);
        check("post_rst_passthrough", longint'(yn_a), 123);

        // Randomised stream against the reference model.
        for (int n = 0; n < 400; n++) begin
            bit     v, we, clr;
            longint x, d;
            int     a;
            v   = ($urandom_range(0, 3) != 0);
            we  = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 29) == 0);
            x   = longint'($urandom_range(0, 65535)) - 32768;
            d   = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 65535)) - 32768
                                              : longint'($urandom_range(0, 8)) - 4;
            a   = $urandom_range(0, 7);
            step(v, x, we, a, d, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
